// File: rtl/cam_regs.sv
// Shared camera-peripheral register map and fetch FSM state encodings.
package cam_regs;

  localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS = 32'h0000_0004;
  localparam logic [31:0] REG_DATA   = 32'h0000_0008;

  localparam int AVAIL = 0;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ARM       = 4'd1;
  localparam logic [3:0] ST_POLL_RD   = 4'd2;
  localparam logic [3:0] ST_POLL_WAIT = 4'd3;
  localparam logic [3:0] ST_DISARM    = 4'd4;
  localparam logic [3:0] ST_SET_ADDR  = 4'd5;
  localparam logic [3:0] ST_SETTLE    = 4'd6;
  localparam logic [3:0] ST_RD_PIX    = 4'd7;
  localparam logic [3:0] ST_PUSH      = 4'd8;
  localparam logic [3:0] ST_DONE      = 4'd9;

endpackage

// File: rtl/wb_single_xfer.sv
// Single Wishbone classic-cycle transfer engine. A held request launches one
// registered read or write; done pulses for one cycle after the ack, with the
// read data captured in rdata. A request is not relaunched during the done
// cycle, so strobes are always separated by idle cycles.
module wb_single_xfer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  // Launch on request, hold the bus until ack, then drop everything together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
      done     <= 1'b0;
      rdata    <= '0;
    end else begin
      done <= 1'b0;
      if (wb_cyc_o) begin
        if (wb_ack_i) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          wb_adr_o <= '0;
          wb_sel_o <= '0;
          wb_dat_o <= '0;
          done     <= 1'b1;
          if (!wb_we_o) rdata <= wb_dat_i;
        end
      end else if (req && !done) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= we;
        wb_adr_o <= adr;
        wb_sel_o <= 4'hF;
        wb_dat_o <= wdata;
      end
    end
  end

endmodule

// File: rtl/wb_cam_fetch.sv
// Wishbone master that arms the camera peripheral, polls for a finished
// picture, disarms it, then streams every pixel out on a valid/ready port.
// Optional poll timeout: define WB_CAM_FETCH_TIMEOUT_EN to abort after
// MAX_POLLS unsuccessful STATUS reads and flag error; otherwise error is 0.
module wb_cam_fetch
  import cam_regs::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_PIX     = 19200,
  parameter int          ADDR_W      = 17,
  parameter int          PIX_W       = 12,
  parameter int          POLL_GAP    = 16,
  parameter int          ADDR_SETTLE = 2,
  parameter int          MAX_POLLS   = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [31:0]       wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);

  logic [3:0]        state;
  logic [ADDR_W-1:0] counter;
  logic [15:0]       wait_cnt;

  logic              xfer_req;
  logic              xfer_we;
  logic [31:0]       xfer_off;
  logic [31:0]       xfer_wdata;
  logic              xfer_done;
  logic [31:0]       xfer_rdata;

`ifdef WB_CAM_FETCH_TIMEOUT_EN
  localparam logic [15:0] POLL_LIMIT = 16'(MAX_POLLS);
  logic [15:0] poll_cnt;
  logic        timed_out;
  logic        error_r;
  assign error = error_r;
`else
  assign error = 1'b0;
`endif

  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign pix_valid = (state == ST_PUSH);

  // Each bus state holds a request describing its register access.
  always_comb begin
    xfer_req   = 1'b0;
    xfer_we    = 1'b0;
    xfer_off   = '0;
    xfer_wdata = '0;
    case (state)
      ST_ARM: begin
        xfer_req   = 1'b1;
        xfer_we    = 1'b1;
        xfer_off   = REG_CTRL;
        xfer_wdata = 32'h1;
      end
      ST_POLL_RD: begin
        xfer_req = 1'b1;
        xfer_off = REG_STATUS;
      end
      ST_DISARM: begin
        xfer_req = 1'b1;
        xfer_we  = 1'b1;
        xfer_off = REG_CTRL;
      end
      ST_SET_ADDR: begin
        xfer_req   = 1'b1;
        xfer_we    = 1'b1;
        xfer_off   = REG_DATA;
        xfer_wdata = 32'(counter);
      end
      ST_RD_PIX: begin
        xfer_req = 1'b1;
        xfer_off = REG_DATA;
      end
      default: ;
    endcase
  end

  wb_single_xfer u_xfer (
    .clk      (clk),
    .reset    (reset),
    .req      (xfer_req),
    .we       (xfer_we),
    .adr      (BASE_ADDR + xfer_off),
    .wdata    (xfer_wdata),
    .done     (xfer_done),
    .rdata    (xfer_rdata),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  // Frame sequencer: arm, poll, disarm, then address/read/push every pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      counter  <= '0;
      wait_cnt <= '0;
      pix_data <= '0;
      pix_addr <= '0;
      pix_last <= 1'b0;
`ifdef WB_CAM_FETCH_TIMEOUT_EN
      poll_cnt  <= '0;
      timed_out <= 1'b0;
      error_r   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_ARM;
            counter <= '0;
`ifdef WB_CAM_FETCH_TIMEOUT_EN
            poll_cnt  <= '0;
            timed_out <= 1'b0;
            error_r   <= 1'b0;
`endif
          end
        end
        ST_ARM: begin
          if (xfer_done) state <= ST_POLL_RD;
        end
        ST_POLL_RD: begin
          if (xfer_done) begin
            if (xfer_rdata[AVAIL]) begin
              state <= ST_DISARM;
            end else begin
              wait_cnt <= '0;
              state    <= ST_POLL_WAIT;
`ifdef WB_CAM_FETCH_TIMEOUT_EN
              poll_cnt <= poll_cnt + 16'd1;
              if (poll_cnt + 16'd1 == POLL_LIMIT) begin
                timed_out <= 1'b1;
                state     <= ST_DISARM;
              end
`endif
            end
          end
        end
        ST_POLL_WAIT: begin
          if (int'(wait_cnt) + 1 >= POLL_GAP) state <= ST_POLL_RD;
          else wait_cnt <= wait_cnt + 16'd1;
        end
        ST_DISARM: begin
          if (xfer_done) begin
            state <= ST_SET_ADDR;
`ifdef WB_CAM_FETCH_TIMEOUT_EN
            if (timed_out) begin
              state   <= ST_DONE;
              error_r <= 1'b1;
            end
`endif
          end
        end
        ST_SET_ADDR: begin
          if (xfer_done) begin
            wait_cnt <= '0;
            state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (int'(wait_cnt) + 1 >= ADDR_SETTLE) state <= ST_RD_PIX;
          else wait_cnt <= wait_cnt + 16'd1;
        end
        ST_RD_PIX: begin
          if (xfer_done) begin
            pix_data <= xfer_rdata[PIX_W-1:0];
            pix_addr <= counter;
            pix_last <= (counter == LAST_IDX);
            state    <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (pix_ready) begin
            if (pix_last) begin
              state <= ST_DONE;
            end else begin
              counter <= counter + ADDR_W'(1);
              state   <= ST_SET_ADDR;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
